// File: rtl/debug_unit_ctrl_pkg.sv
// debug_unit_pkg: shared widths, command bytes and FSM states for the debug unit
package debug_unit_pkg;
  localparam int NB_DATA = 8;
  localparam int NB_WORD = 32;
  localparam int NB_IMEM_ADDR = 8;
  localparam int NB_REG_ADDR = 5;
  localparam int DUMP_WORDS = 33;
  localparam int BYTES_PER_WORD = 4;
  localparam logic [NB_DATA-1:0] CMD_LOAD = 8'h4C;
  localparam logic [NB_DATA-1:0] CMD_RUN = 8'h52;
  localparam logic [NB_DATA-1:0] CMD_STEP = 8'h53;
  localparam logic [NB_DATA-1:0] ACK = 8'h06;
  typedef enum logic [3:0] {
    IDLE, LD_COUNT, LD_BYTE, LD_WRITE, LD_ACK, RUN, STEP, DUMP_LOAD, DUMP_SEND, DUMP_WAIT
  } state_t;
endpackage

// File: rtl/debug_unit_ctrl_if.sv
// debug_unit_ctrl_if: UART, instruction memory and core debug signals of the debug unit
interface debug_unit_ctrl_if;
  import debug_unit_pkg::*;
  logic [NB_DATA-1:0] rx_data_i;
  logic rx_valid_i;
  logic tx_done_i;
  logic [NB_DATA-1:0] tx_data_o;
  logic tx_start_o;
  logic imem_we_o;
  logic [NB_IMEM_ADDR-1:0] imem_addr_o;
  logic [NB_WORD-1:0] imem_data_o;
  logic cpu_run_o;
  logic cpu_step_o;
  logic cpu_halt_i;
  logic [NB_WORD-1:0] pc_i;
  logic [NB_REG_ADDR-1:0] reg_addr_o;
  logic [NB_WORD-1:0] reg_data_i;
  logic busy_o;
  modport master (
    input rx_data_i, rx_valid_i, tx_done_i, cpu_halt_i, pc_i, reg_data_i,
    output tx_data_o, tx_start_o, imem_we_o, imem_addr_o, imem_data_o,
    output cpu_run_o, cpu_step_o, reg_addr_o, busy_o
  );
  modport slave (
    output rx_data_i, rx_valid_i, tx_done_i, cpu_halt_i, pc_i, reg_data_i,
    input tx_data_o, tx_start_o, imem_we_o, imem_addr_o, imem_data_o,
    input cpu_run_o, cpu_step_o, reg_addr_o, busy_o
  );
endinterface

// File: rtl/debug_unit_ctrl_serializer.sv
// dbg_word_serializer: shifts a word out MSB-first, one byte per tx_done; single mode sends only the top byte
module dbg_word_serializer
  import debug_unit_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic single,
  input  logic [NB_WORD-1:0] word,
  input  logic tx_done,
  output logic [NB_DATA-1:0] tx_data,
  output logic word_done
);
  logic [NB_WORD-1:0] sh;
  logic [1:0] cnt;
  always_ff @(posedge clock) begin
    if (reset) begin
      sh <= '0;
      cnt <= '0;
    end else if (load) begin
      sh <= word;
      cnt <= single ? 2'(BYTES_PER_WORD - 1) : 2'd0;
    end else if (tx_done) begin
      sh <= sh << NB_DATA;
      cnt <= cnt + 2'd1;
    end
  end
  assign tx_data = sh[NB_WORD-1 -: NB_DATA];
  assign word_done = tx_done && cnt == 2'(BYTES_PER_WORD - 1);
endmodule

// File: rtl/debug_unit_ctrl.sv
// debug_unit_ctrl: UART command sequencer that loads imem, runs/steps the core and dumps PC plus registers
module debug_unit_ctrl
  import debug_unit_pkg::*;
(
  input logic clock,
  input logic reset,
  debug_unit_ctrl_if.master bus
);
  state_t state, state_n;
  logic [NB_IMEM_ADDR-1:0] addr, last_addr;
  logic [1:0] lcnt;
  logic [NB_WORD-1:0] ld_word, ser_word;
  logic [5:0] widx;
  logic ack_sent, ser_load, ser_single, tx_done, word_done, rx, last_word;
  assign rx = bus.rx_valid_i;
  assign last_word = addr == last_addr;
  assign tx_done = bus.tx_done_i && (state == DUMP_WAIT || state == LD_ACK);
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (rx) state_n = bus.rx_data_i == CMD_LOAD ? LD_COUNT :
                              bus.rx_data_i == CMD_RUN  ? RUN :
                              bus.rx_data_i == CMD_STEP ? STEP : IDLE;
      LD_COUNT: if (rx) state_n = LD_BYTE;
      LD_BYTE: if (rx && lcnt == 2'd3) state_n = LD_WRITE;
      LD_WRITE: state_n = last_word ? LD_ACK : LD_BYTE;
      LD_ACK: if (tx_done) state_n = IDLE;
      RUN: if (bus.cpu_halt_i) state_n = DUMP_LOAD;
      STEP: state_n = DUMP_LOAD;
      DUMP_LOAD: state_n = DUMP_SEND;
      DUMP_SEND: state_n = DUMP_WAIT;
      DUMP_WAIT: if (tx_done) state_n = !word_done ? DUMP_SEND :
                                        widx == 6'(DUMP_WORDS) ? IDLE : DUMP_LOAD;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      addr <= '0;
      last_addr <= '0;
      lcnt <= '0;
      ld_word <= '0;
      widx <= '0;
      ack_sent <= 1'b0;
    end else begin
      state <= state_n;
      ack_sent <= state == LD_ACK;
      if (state == IDLE) addr <= '0;
      if (state == LD_WRITE) addr <= addr + 1'b1;
      // N=0 wraps to 255, so a count of 0 loads all 256 words
      if (state == LD_COUNT && rx) begin
        last_addr <= bus.rx_data_i - 8'd1;
        lcnt <= '0;
      end
      if (state == LD_BYTE && rx) begin
        ld_word <= {ld_word[NB_WORD-NB_DATA-1:0], bus.rx_data_i};
        lcnt <= lcnt + 2'd1;
      end
      if (state == RUN || state == STEP) widx <= '0;
      if (state == DUMP_LOAD) widx <= widx + 6'd1;
    end
  end
  assign ser_load = state == DUMP_LOAD || (state == LD_WRITE && last_word);
  assign ser_single = state == LD_WRITE;
  assign ser_word = state == LD_WRITE ? {ACK, 24'h0} : widx == '0 ? bus.pc_i : bus.reg_data_i;
  dbg_word_serializer u_ser (
    .clock(clock), .reset(reset), .load(ser_load), .single(ser_single), .word(ser_word),
    .tx_done(tx_done), .tx_data(bus.tx_data_o), .word_done(word_done)
  );
  assign bus.tx_start_o = state == DUMP_SEND || (state == LD_ACK && !ack_sent);
  assign bus.imem_we_o = state == LD_WRITE;
  assign bus.imem_addr_o = addr;
  assign bus.imem_data_o = ld_word;
  assign bus.cpu_run_o = state == RUN && !bus.cpu_halt_i;
  assign bus.cpu_step_o = state == STEP;
  assign bus.reg_addr_o = state == DUMP_LOAD ? NB_REG_ADDR'(widx - 6'd1) : '0;
  assign bus.busy_o = state != IDLE;
endmodule

// File: tb/tb_debug_unit_ctrl.sv
// tb_debug_unit_ctrl: scoreboard bench with UART/core models and randomized command traffic
module tb_debug_unit_ctrl;
  import debug_unit_pkg::*;
  logic clock = 1'b0;
  logic reset = 1'b1;
  debug_unit_ctrl_if bus();
  debug_unit_ctrl dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  int errors = 0, checks = 0, run_cycles = 0, step_cnt = 0, imem_cnt = 0;
  bit outst = 1'b0;
  logic [7:0] exp_tx[$];
  logic [39:0] exp_imem[$];
  logic [31:0] wq[$];
  logic [31:0] regs[32];
  assign bus.reg_data_i = regs[bus.reg_addr_o];
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [63:0] outs();
    return 64'({bus.tx_data_o, bus.tx_start_o, bus.imem_we_o, bus.imem_addr_o, bus.imem_data_o,
                bus.cpu_run_o, bus.cpu_step_o, bus.reg_addr_o, bus.busy_o});
  endfunction
  always @(negedge clock) begin
    if (reset) outst = 1'b0;
    else begin
      if (bus.imem_we_o) begin
        imem_cnt++;
        if (exp_imem.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL imem_extra: write %0h at %0h, none expected", bus.imem_data_o, bus.imem_addr_o);
        end else check("imem_write", {bus.imem_addr_o, bus.imem_data_o}, exp_imem.pop_front());
      end
      if (bus.tx_start_o) begin
        check("tx_overlap", 64'(outst), 64'd0);
        outst = 1'b1;
        if (exp_tx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_extra: byte %0h, none expected", bus.tx_data_o);
        end else check("tx_byte", bus.tx_data_o, exp_tx.pop_front());
      end
      if (bus.tx_done_i) outst = 1'b0;
      if (bus.cpu_run_o) run_cycles++;
      if (bus.cpu_step_o) step_cnt++;
    end
  end
  initial forever begin
    @(negedge clock);
    if (bus.tx_start_o && !reset) begin
      repeat ($urandom_range(1, 4)) @(posedge clock);
      #1 bus.tx_done_i = 1'b1;
      @(posedge clock);
      #1 bus.tx_done_i = 1'b0;
    end
  end
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  task automatic send_byte(input logic [7:0] b);
    @(posedge clock);
    #1 bus.rx_data_i = b;
    bus.rx_valid_i = 1'b1;
    @(posedge clock);
    #1 bus.rx_valid_i = 1'b0;
  endtask
  task automatic wait_idle(input string name);
    int n = 0;
    while (n < 20000) begin
      @(negedge clock);
      if (!bus.busy_o) break;
      n++;
    end
    check(name, 64'(n < 20000), 64'd1);
  endtask
  task automatic do_load();
    int n = wq.size();
    for (int k = 0; k < n; k++) exp_imem.push_back({8'(k), wq[k]});
    exp_tx.push_back(ACK);
    send_byte(CMD_LOAD);
    send_byte(8'(n));
    for (int k = 0; k < n; k++)
      for (int b = 3; b >= 0; b--) begin
        send_byte(wq[k][8*b +: 8]);
        repeat ($urandom_range(0, 2)) @(posedge clock);
      end
    wait_idle("load_idle");
    check("load_imem_left", 64'(exp_imem.size()), 64'd0);
    check("load_ack_left", 64'(exp_tx.size()), 64'd0);
  endtask
  task automatic rand_words(input int n);
    wq.delete();
    for (int k = 0; k < n; k++) wq.push_back($urandom);
  endtask
  task automatic prep_dump();
    bus.pc_i = $urandom;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    for (int b = 3; b >= 0; b--) exp_tx.push_back(bus.pc_i[8*b +: 8]);
    for (int i = 0; i < 32; i++)
      for (int b = 3; b >= 0; b--) exp_tx.push_back(regs[i][8*b +: 8]);
  endtask
  task automatic do_run(input int halt_after);
    run_cycles = 0;
    prep_dump();
    if (halt_after == 0) bus.cpu_halt_i = 1'b1;
    send_byte(CMD_RUN);
    repeat (halt_after) @(posedge clock);
    #1 bus.cpu_halt_i = 1'b1;
    wait_idle("run_idle");
    check("run_cycles", 64'(run_cycles), 64'(halt_after));
    check("run_dump_left", 64'(exp_tx.size()), 64'd0);
    bus.cpu_halt_i = 1'b0;
  endtask
  task automatic do_step();
    run_cycles = 0;
    step_cnt = 0;
    prep_dump();
    send_byte(CMD_STEP);
    repeat ($urandom_range(40, 120)) @(posedge clock);
    send_byte(CMD_RUN);
    wait_idle("step_idle");
    repeat (20) @(negedge clock);
    check("step_pulses", 64'(step_cnt), 64'd1);
    check("step_no_run", 64'(run_cycles), 64'd0);
    check("step_dump_left", 64'(exp_tx.size()), 64'd0);
  endtask
  initial begin
    logic act;
    bus.rx_data_i = '0;
    bus.rx_valid_i = 1'b0;
    bus.tx_done_i = 1'b0;
    bus.cpu_halt_i = 1'b0;
    bus.pc_i = '0;
    for (int i = 0; i < 32; i++) regs[i] = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_outputs", outs(), 64'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    wq.delete();
    wq.push_back(32'h20080005);
    wq.push_back(32'hAC010004);
    do_load();
    act = 1'b0;
    send_byte(8'h41);
    repeat (30) begin
      @(negedge clock);
      act = act | bus.busy_o | bus.tx_start_o | bus.imem_we_o | bus.cpu_run_o | bus.cpu_step_o;
    end
    check("idle_ignore", 64'(act), 64'd0);
    do_run(10);
    do_step();
    send_byte(CMD_LOAD);
    send_byte(8'd2);
    send_byte(8'hDE);
    send_byte(8'hAD);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("midload_reset_outputs", outs(), 64'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    rand_words(1);
    do_load();
    imem_cnt = 0;
    rand_words(256);
    do_load();
    check("load256_writes", 64'(imem_cnt), 64'd256);
    do_run(0);
    for (int r = 0; r < 4; r++) begin
      rand_words($urandom_range(1, 6));
      do_load();
      do_run($urandom_range(0, 15));
      do_step();
    end
    check("final_tx_left", 64'(exp_tx.size()), 64'd0);
    check("final_imem_left", 64'(exp_imem.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
